// File: rtl/shift_out_reg_4b.sv
// shift_out_reg_4b: parallel-in, serial-out unload register.
// A word is captured on a load request while ready is high. It is then shifted
// out one bit per clock with a valid qualifier. A one-cycle done strobe closes
// the frame, and the block returns to ready.
// Optional feature macro: SHIFT_OUT_PARITY_EN appends an even-parity bit
// after the last data bit of every frame.
module shift_out_reg_4b #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             ld,
   output logic             ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
`ifdef SHIFT_OUT_PARITY_EN
      DONE   = 2'd2,
      PARITY = 2'd3
`else
      DONE  = 2'd2
`endif
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    count;
`ifdef SHIFT_OUT_PARITY_EN
   logic             par;
`endif

   // Bit that leaves the register next. Which end this is depends on the
   // shift direction.
   function automatic logic out_bit(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   // Move the word one place toward the output end and fill with zero.
   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
   endfunction

   // Frame FSM with registered outputs. On load, bit 0 of the frame goes
   // straight into sout. shreg then holds the word already advanced by one
   // place, so that sout and the register stay one step apart.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shreg      <= '0;
         count      <= '0;
         ready      <= 1'b1;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         done       <= 1'b0;
`ifdef SHIFT_OUT_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (ld) begin
                  shreg      <= shift_once(in);
                  sout       <= out_bit(in);
                  sout_valid <= 1'b1;
                  ready      <= 1'b0;
                  count      <= '0;
`ifdef SHIFT_OUT_PARITY_EN
                  par        <= ^in;
`endif
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               if (count == LAST_CNT) begin
`ifdef SHIFT_OUT_PARITY_EN
                  sout       <= par;
                  state      <= PARITY;
`else
                  sout       <= 1'b0;
                  sout_valid <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
`endif
               end else begin
                  sout  <= out_bit(shreg);
                  shreg <= shift_once(shreg);
                  count <= count + CW'(1);
               end
            end
`ifdef SHIFT_OUT_PARITY_EN
            PARITY: begin
               sout       <= 1'b0;
               sout_valid <= 1'b0;
               done       <= 1'b1;
               state      <= DONE;
            end
`endif
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               sout       <= 1'b0;
               sout_valid <= 1'b0;
               done       <= 1'b0;
               ready      <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_out_reg_4b.sv
// Testbench for shift_out_reg_4b. Two instances share the same stimulus:
// one shifts MSB first and the other LSB first.
// A frame-position model predicts every output on every cycle. Directed
// literal expectations pin the bit order, timing and corner cases.
// Build with SHIFT_OUT_PARITY_EN defined to exercise the parity frame.
module tb_shift_out_reg_4b;

   localparam int WIDTH = 4;
`ifdef SHIFT_OUT_PARITY_EN
   localparam int FRAME = WIDTH + 3;
`else
   localparam int FRAME = WIDTH + 2;
`endif
   // Frame positions: 0 idle, 1..WIDTH data bits, then parity (if enabled),
   // and the last position is the done cycle.
   localparam int LAST = FRAME - 1;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] in;
   logic             ld;
   logic             rdy0, so0, sv0, dn0;
   logic             rdy1, so1, sv1, dn1;

   int errs   = 0;
   int checks = 0;
   int cyc    = 0;
   int dcount0 = 0;

   shift_out_reg_4b #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .in(in), .ld(ld),
      .ready(rdy0), .sout(so0), .sout_valid(sv0), .done(dn0)
   );

   shift_out_reg_4b #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .in(in), .ld(ld),
      .ready(rdy1), .sout(so1), .sout_valid(sv1), .done(dn1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;
   always @(negedge clk) if (dn0 === 1'b1) dcount0++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: position within the current frame and the captured word.
   int               ph [2];
   logic [WIDTH-1:0] wd [2];

   initial begin
      ph[0] = 0; ph[1] = 0; wd[0] = '0; wd[1] = '0;
   end

   always @(posedge clk or negedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst) ph[i] = 0;
         else if (ph[i] == 0) begin
            if (ld) begin ph[i] = 1; wd[i] = in; end
         end else if (ph[i] == LAST) ph[i] = 0;
         else ph[i] = ph[i] + 1;
      end
   end

   // Expected {ready, sout, sout_valid, done} for a frame position.
   function automatic logic [3:0] model_out(input int p, input logic [WIDTH-1:0] w, input bit msb);
      logic b;
      if (p == 0) return 4'b1000;
      if (p <= WIDTH) begin
         b = msb ? w[WIDTH-p] : w[p-1];
         return {1'b0, b, 1'b1, 1'b0};
      end
`ifdef SHIFT_OUT_PARITY_EN
      if (p == WIDTH + 1) return {1'b0, ^w, 1'b1, 1'b0};
`endif
      return 4'b0001;
   endfunction

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      chk("model_msb", {28'd0, rdy0, so0, sv0, dn0}, {28'd0, model_out(ph[0], wd[0], 1'b1)});
      chk("model_lsb", {28'd0, rdy1, so1, sv1, dn1}, {28'd0, model_out(ph[1], wd[1], 1'b0)});
   end

   // One-edge load pulse; returns just after the load edge.
   task automatic load(input logic [WIDTH-1:0] w);
      in = w;
      ld = 1'b1;
      @(posedge clk);
      #2 ld = 1'b0;
   endtask

   // Collect the four data bits in output order from both instances.
   task automatic collect(output logic [3:0] ms, output logic [3:0] ls);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bit_valid", {31'd0, sv0}, 32'd1);
         ms[3-k] = so0;
         ls[3-k] = so1;
      end
   endtask

   // After the last data bit: optional parity bit, done strobe, then ready.
   task automatic finish_frame(input logic par_exp);
`ifdef SHIFT_OUT_PARITY_EN
      @(negedge clk);
      chk("par_valid", {31'd0, sv0}, 32'd1);
      chk("par_bit", {31'd0, so0}, {31'd0, par_exp});
      chk("par_no_done", {31'd0, dn0}, 32'd0);
`else
      if (par_exp === 1'bx) chk("par_arg", 32'd0, 32'd1);
`endif
      @(negedge clk);
      chk("done_strobe", {31'd0, dn0}, 32'd1);
      chk("done_no_valid", {31'd0, sv0}, 32'd0);
      chk("done_not_ready", {31'd0, rdy0}, 32'd0);
      @(negedge clk);
      chk("ready_again", {31'd0, rdy0}, 32'd1);
      chk("done_single", {31'd0, dn0}, 32'd0);
   endtask

   initial begin
      logic [3:0] ms, ls;
      int n, t1, t2, dc;

      // Test 1: reset held with ld high.
      rst = 1'b0; ld = 1'b1; in = 4'b1111;
      repeat (3) begin
         @(negedge clk);
         chk("rst_ready", {31'd0, rdy0}, 32'd1);
         chk("rst_outs", {29'd0, so0, sv0, dn0}, 32'd0);
      end
      rst = 1'b1; ld = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_no_frame", {30'd0, rdy0, sv0}, 32'd2);

      // Test 2: single frame 0101.
      load(4'b0101);
      collect(ms, ls);
      chk("seq_0101_msb", {28'd0, ms}, 32'h5);
      chk("seq_0101_lsb", {28'd0, ls}, 32'hA);
      finish_frame(1'b0);

      // Test 3: input change and ld pulse during SHIFT are ignored.
      dc = dcount0;
      load(4'b1010);
      in = 4'b1110; ld = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ms[3-k] = so0;
         if (k == 0) begin @(posedge clk); #2 ld = 1'b0; end
      end
      chk("seq_1010_msb", {28'd0, ms}, 32'hA);
      finish_frame(1'b0);
      repeat (2) @(negedge clk);
      chk("no_requeue", {30'd0, rdy0, sv0}, 32'd2);
      #1 chk("one_done", dcount0 - dc, 1);

      // Test 4: ld held high, back-to-back frames.
      in = 4'b1011; ld = 1'b1;
      n = 0;
      while (!sv0 && n < 20) begin @(posedge clk); #2; n++; end
      chk("hold_start", {31'd0, sv0}, 32'd1);
      collect(ms, ls);
      chk("seq_1011_msb", {28'd0, ms}, 32'hB);
      chk("seq_1011_lsb", {28'd0, ls}, 32'hD);
      n = 0;
      do begin @(negedge clk); n++; end while (!dn0 && n < 20);
      t1 = cyc;
      n = 0;
      do begin @(negedge clk); n++; end while (!dn0 && n < 20);
      t2 = cyc;
      chk("frame_period", t2 - t1, FRAME);
      ld = 1'b0;
      repeat (FRAME + 1) @(negedge clk);
      chk("hold_idle", {31'd0, rdy0}, 32'd1);

      // Test 5: asynchronous reset mid-frame.
      dc = dcount0;
      load(4'b1100);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_bit1", {30'd0, so0, sv0}, 32'd3);
      #2 rst = 1'b0;
      #1;
      chk("async_ready", {31'd0, rdy0}, 32'd1);
      chk("async_outs", {29'd0, so0, sv0, dn0}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk("rst_no_done", dcount0 - dc, 0);
      load(4'b0011);
      collect(ms, ls);
      chk("seq_0011_msb", {28'd0, ms}, 32'h3);
      finish_frame(1'b0);

`ifdef SHIFT_OUT_PARITY_EN
      // Test 6: parity bit appended.
      load(4'b1011);
      collect(ms, ls);
      chk("par_seq_1011", {28'd0, ms}, 32'hB);
      finish_frame(1'b1);
      load(4'b1001);
      collect(ms, ls);
      chk("par_seq_1001", {28'd0, ms}, 32'h9);
      finish_frame(1'b0);
`endif

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/shift_out_reg_4b.md
Name: shift_out_reg_4b

Overview:
Parallel-in, serial-out unload register: the reader side of the 4-bit load register.
Captures a parallel word on a load request and shifts it out one bit per clock, MSB first, with a valid qualifier.
Raises a one-cycle done strobe at the end of each frame and signals readiness for the next word.
Sits between datapath load registers and serial consumers such as test/debug taps or inter-block serial links.

Parameters:
WIDTH, 4, data word width in bits (>=2); counter width = clog2(WIDTH)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
in  input  WIDTH  parallel word to unload
ld  input  1  load request; sampled only while ready=1
ready  output  1  1 = IDLE, ld will be accepted at next rising edge
sout  output  1  serial data bit
sout_valid  output  1  1 = sout carries a frame bit this cycle
done  output  1  one-cycle strobe after last frame bit

Behaviour:
- Reset (rst=0, asynchronous, no clock needed): state=IDLE, shreg=0, count=0, ready=1, sout=0, sout_valid=0, done=0. Held while rst=0.
- States: IDLE, SHIFT, DONE (plus PARITY with macro). All state, shreg and count are registered; outputs decode from registers only (no ld/in combinational paths to outputs).
- IDLE: ready=1, sout_valid=0, sout=0, done=0. Rising edge with ld=1: shreg<=in, count<=0, state<=SHIFT. ld=0: stay.
- SHIFT: ready=0, sout_valid=1, sout = shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0). Each edge: shreg shifts toward the output end, zero-filled; count<=count+1. When count==WIDTH-1: state<=DONE (PARITY with macro).
- DONE: ready=0, sout_valid=0, sout=0, done=1 for exactly one cycle; next edge state<=IDLE.
- Latency: load edge at T0 -> bit k valid in the cycle after edge T0+k (k=0..WIDTH-1). done is high in the cycle after edge T0+WIDTH. ready=1 again after edge T0+WIDTH+1. Frame period = WIDTH+2 cycles.
- ld while ready=0 (SHIFT/DONE): ignored, no queuing.
- in changes after the load edge: no effect on the frame in progress.
- ld held high continuously: a new frame loads on the edge that leaves IDLE. Frames repeat every WIDTH+2 cycles.
- rst asserted mid-frame: frame abandoned immediately, outputs go to reset values, no done strobe.
- rst deasserted: first possible load is on the next rising edge where rst=1 and ld=1.

Optional Feature:
SHIFT_OUT_PARITY_EN
- Defined: at the load edge, also store par = ^in (the XOR of the word bits). The XOR alone makes the ones-count including par even. After the last data bit, enter PARITY for one cycle: sout=par, sout_valid=1, ready=0. Then DONE. Frame period = WIDTH+3 cycles; done is one cycle later.
- Undefined: no par register, no PARITY state, behaviour exactly as above.

Test Plan:
1. rst=0 with clk running and ld=1, in=4'b1111 -> ready=1, sout=0, sout_valid=0, done=0 throughout. Release rst: no frame until ld is sampled high while ready=1.
2. in=4'b0101, ld=1 for one edge (MSB_FIRST=1) -> sout_valid=1 for 4 cycles with sout=0,1,0,1. Then done=1 for one cycle with sout_valid=0. Then ready=1.
3. Load in=4'b1010, change in to 4'b1110 and pulse ld during SHIFT -> sout=1,0,1,0, single done, second ld ignored.
4. ld held high, in=4'b1011 -> frames 1,0,1,1 repeat with period 6 cycles, done pulses 6 cycles apart. With MSB_FIRST=0: 1,1,0,1.
5. Load 4'b1100, assert rst=0 after 2 valid bits (mid-cycle, between edges) -> sout_valid=0 and ready=1 immediately, no done. After release, load 4'b0011 -> 0,0,1,1 normally.
6. With SHIFT_OUT_PARITY_EN: load 4'b1011 -> sout=1,0,1,1 then parity 1 (sout_valid=1), then done. Load 4'b1001 -> parity bit 0, frame period 7 cycles.
